// File: rtl/spi_bus_bridge.sv
// spi_bus_bridge: front end between the 6809 bus and the SPI flash controller.
// Brings the asynchronous E/Q/RW strobes into the clk domain and decodes the
// 4 KB flash window. It then issues one request per bus cycle, holding MRDY low
// until read data returns or the watchdog gives up.
//
//  state     | meaning
//  ----------+-----------------------------------------------------------
//  IDLE      | waiting for Q-rise with an address in the flash window
//  WAIT_DATA | write accepted, waiting for E-rise to sample CPU data
//  REQ       | request pending, held off while the controller is busy
//  WAIT_DONE | read issued, waiting for the controller's done pulse
//  RELEASE   | access finished, hold the data bus until E-fall
module spi_bus_bridge #(
    parameter logic [15:0] BASE_ADDR      = 16'hE000,
    parameter int          SYNC_STAGES    = 2,
    parameter int          TIMEOUT_CYCLES = 1023
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_E,
    input  logic        i_Q,
    input  logic        i_RW,
    input  logic [15:0] i_ADDRESS_BUS,
    input  logic [7:0]  i_DataBus,
    input  logic        i_spi_busy,
    input  logic        i_spi_done,
    input  logic [7:0]  i_spi_rdata,
    output logic        o_rd_req,
    output logic        o_wr_req,
    output logic [11:0] o_addr,
    output logic [7:0]  o_wdata,
    output logic [7:0]  o_data_out,
    output logic        o_data_oe,
    output logic        o_MemoryReady,
    output logic        o_timeout
);

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] WAIT_DATA = 3'd1;
    localparam logic [2:0] REQ       = 3'd2;
    localparam logic [2:0] WAIT_DONE = 3'd3;
    localparam logic [2:0] RELEASE   = 3'd4;

    localparam int               CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
    // Abort decision is taken in the cycle whose increment would reach the limit.
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [SYNC_STAGES-1:0] r_e_sync;
    logic [SYNC_STAGES-1:0] r_q_sync;
    logic [SYNC_STAGES-1:0] r_rw_sync;
    logic                   r_e_d;
    logic                   r_q_d;

    logic [2:0]       r_state;
    logic             r_is_read;
    logic [CNT_W-1:0] r_tmo_cnt;
    logic             r_rd_req;
    logic             r_wr_req;
    logic [11:0]      r_addr;
    logic [7:0]       r_wdata;
    logic [7:0]       r_data_out;
    logic             r_data_oe;
    logic             r_mrdy;
    logic             r_timeout;

    logic w_e_rise;
    logic w_e_fall;
    logic w_q_rise;
    logic w_rw;
    logic w_addr_hit;
    logic w_tmo_hit;

    assign w_e_rise   = r_e_sync[SYNC_STAGES-1] & ~r_e_d;
    assign w_e_fall   = ~r_e_sync[SYNC_STAGES-1] & r_e_d;
    assign w_q_rise   = r_q_sync[SYNC_STAGES-1] & ~r_q_d;
    assign w_rw       = r_rw_sync[SYNC_STAGES-1];
    assign w_addr_hit = (i_ADDRESS_BUS[15:12] == BASE_ADDR[15:12]);
    assign w_tmo_hit  = (r_tmo_cnt == TMO_LAST);

    // Synchronise the bus strobes and keep one delayed copy for edge detection.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_e_sync  <= '0;
            r_q_sync  <= '0;
            r_rw_sync <= '0;
            r_e_d     <= 1'b0;
            r_q_d     <= 1'b0;
        end else begin
            r_e_sync  <= {r_e_sync[SYNC_STAGES-2:0], i_E};
            r_q_sync  <= {r_q_sync[SYNC_STAGES-2:0], i_Q};
            r_rw_sync <= {r_rw_sync[SYNC_STAGES-2:0], i_RW};
            r_e_d     <= r_e_sync[SYNC_STAGES-1];
            r_q_d     <= r_q_sync[SYNC_STAGES-1];
        end
    end

    // Access sequencer: decode, request, wait for data or abort, release bus.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state    <= IDLE;
            r_is_read  <= 1'b0;
            r_tmo_cnt  <= '0;
            r_rd_req   <= 1'b0;
            r_wr_req   <= 1'b0;
            r_addr     <= 12'h000;
            r_wdata    <= 8'h00;
            r_data_out <= 8'h00;
            r_data_oe  <= 1'b0;
            r_mrdy     <= 1'b1;
            r_timeout  <= 1'b0;
        end else begin
            r_rd_req  <= 1'b0;
            r_wr_req  <= 1'b0;
            r_timeout <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_q_rise && w_addr_hit) begin
                        r_addr    <= i_ADDRESS_BUS[11:0];
                        r_is_read <= w_rw;
                        r_mrdy    <= 1'b0;
                        r_tmo_cnt <= '0;
                        r_state   <= w_rw ? REQ : WAIT_DATA;
                    end
                end
                WAIT_DATA: begin
                    if (w_e_rise) begin
                        r_wdata   <= i_DataBus;
                        r_tmo_cnt <= '0;
                        r_state   <= REQ;
                    end
                end
                REQ: begin
                    // A stuck busy line must not stall the CPU forever, so the
                    // watchdog is checked before trying to issue.
                    if (w_tmo_hit) begin
                        r_timeout <= 1'b1;
                        r_mrdy    <= 1'b1;
                        if (r_is_read) begin
                            r_data_out <= 8'hFF;
                            r_data_oe  <= 1'b1;
                        end
                        r_state <= RELEASE;
                    end else begin
                        r_tmo_cnt <= r_tmo_cnt + 1'b1;
                        if (!i_spi_busy) begin
                            if (r_is_read) begin
                                r_rd_req <= 1'b1;
                                r_state  <= WAIT_DONE;
                            end else begin
                                // Writes are posted: release the CPU with the request.
                                r_wr_req <= 1'b1;
                                r_mrdy   <= 1'b1;
                                r_state  <= RELEASE;
                            end
                        end
                    end
                end
                WAIT_DONE: begin
                    if (i_spi_done) begin
                        r_data_out <= i_spi_rdata;
                        r_data_oe  <= 1'b1;
                        r_mrdy     <= 1'b1;
                        r_state    <= RELEASE;
                    end else if (w_tmo_hit) begin
                        r_timeout  <= 1'b1;
                        r_data_out <= 8'hFF;
                        r_data_oe  <= 1'b1;
                        r_mrdy     <= 1'b1;
                        r_state    <= RELEASE;
                    end else begin
                        r_tmo_cnt <= r_tmo_cnt + 1'b1;
                    end
                end
                RELEASE: begin
                    if (w_e_fall) begin
                        r_data_oe <= 1'b0;
                        r_state   <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign o_rd_req      = r_rd_req;
    assign o_wr_req      = r_wr_req;
    assign o_addr        = r_addr;
    assign o_wdata       = r_wdata;
    assign o_data_out    = r_data_out;
    assign o_data_oe     = r_data_oe;
    assign o_MemoryReady = r_mrdy;
    assign o_timeout     = r_timeout;

endmodule
